// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush squash.
// Optional performance counters (bubble_cnt, flush_cnt) are built when IDEX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [9:0]        id_ctrl,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_valid,
  output logic [9:0]        ex_ctrl,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              stall
);

  logic              r_valid;
  logic [9:0]        r_ctrl;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [2:0]        r_funct3;
  logic [6:0]        r_funct7;

  logic w_use_rs1;
  logic w_use_rs2;
  logic w_hazard;

  // Jumps take no rs1; rs2 matters for register-register ops, branches and stores.
  assign w_use_rs1 = ~id_ctrl[9];
  assign w_use_rs2 = ~id_ctrl[0] | id_ctrl[4];

  assign w_hazard = r_valid & r_ctrl[3] & (r_rd != '0) & id_valid &
                    ((w_use_rs1 & (r_rd == id_rs1)) | (w_use_rs2 & (r_rd == id_rs2)));

  // A flush kills the dependent instruction anyway, so holding upstream is pointless.
  assign stall = w_hazard & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_pc     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
    end else if (flush || w_hazard) begin
      // Bubble: only valid and control are cleared; data fields hold to save toggling.
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid  <= id_valid;
      r_ctrl   <= id_valid ? id_ctrl : '0;
      r_pc     <= id_pc;
      r_rd1    <= id_rd1;
      r_rd2    <= id_rd2;
      r_imm    <= id_imm;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
      r_funct3 <= id_funct3;
      r_funct7 <= id_funct7;
    end
  end

  assign ex_valid  = r_valid;
  assign ex_ctrl   = r_ctrl;
  assign ex_pc     = r_pc;
  assign ex_rd1    = r_rd1;
  assign ex_rd2    = r_rd2;
  assign ex_imm    = r_imm;
  assign ex_rs1    = r_rs1;
  assign ex_rs2    = r_rs2;
  assign ex_rd     = r_rd;
  assign ex_funct3 = r_funct3;
  assign ex_funct7 = r_funct7;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  // Flush has priority, so a hazard overridden by flush counts only as a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else if (flush) begin
      r_flush_cnt  <= r_flush_cnt + 32'd1;
    end else if (w_hazard) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed load-use/flush scenarios followed by random traffic.
module tb_id_ex_stage_reg;
  localparam int DW = 32;
  localparam int PW = 9;
  localparam int AW = 5;

  typedef struct packed {
    logic          valid;
    logic [9:0]    ctrl;
    logic [PW-1:0] pc;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [2:0]    f3;
    logic [6:0]    f7;
  } slot_t;

  typedef struct packed {
    slot_t       s;
    logic        chk_data;
    logic [31:0] bc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, id_valid, flush;
  logic [9:0] id_ctrl;
  logic [PW-1:0] id_pc;
  logic [DW-1:0] id_rd1, id_rd2, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic ex_valid, stall;
  logic [9:0] ex_ctrl;
  logic [PW-1:0] ex_pc;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage_reg #(.DATA_W(DW), .PC_W(PW), .RA_W(AW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7),
`ifdef IDEX_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
`endif
    .stall(stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic  q_stall[$];
  exp_t  q_ex[$];

  // Reference view of what EX should hold, updated once per issued cycle.
  slot_t       m_ex = '0;
  logic [31:0] m_bc = '0;
  logic [31:0] m_fc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic v, input logic [9:0] c, input logic [AW-1:0] s1,
                               input logic [AW-1:0] s2, input logic [AW-1:0] d);
    slot_t x;
    x.valid = v;  x.ctrl = c;  x.rs1 = s1;  x.rs2 = s2;  x.rd = d;
    x.pc  = PW'($urandom);
    x.rd1 = $urandom;  x.rd2 = $urandom;  x.imm = $urandom;
    x.f3  = 3'($urandom);  x.f7 = 7'($urandom);
    return x;
  endfunction

  // Issue one cycle of decode-side stimulus; returns the stall the rules predict.
  task automatic step(input logic r, input logic f, input slot_t d, output logic st);
    logic uses1, uses2, haz;
    exp_t e;
    @(negedge clk);
    reset = r;  flush = f;
    id_valid = d.valid;  id_ctrl = d.ctrl;  id_pc = d.pc;
    id_rd1 = d.rd1;  id_rd2 = d.rd2;  id_imm = d.imm;
    id_rs1 = d.rs1;  id_rs2 = d.rs2;  id_rd = d.rd;
    id_funct3 = d.f3;  id_funct7 = d.f7;

    uses1 = !d.ctrl[9];
    uses2 = !d.ctrl[0] || d.ctrl[4];
    haz = m_ex.valid && m_ex.ctrl[3] && (m_ex.rd != 0) && d.valid &&
          ((uses1 && m_ex.rd == d.rs1) || (uses2 && m_ex.rd == d.rs2));
    st = haz && !f;
    q_stall.push_back(st);

    if (r) begin
      m_ex = '0;  m_bc = 0;  m_fc = 0;  e.chk_data = 1'b1;
    end else if (f || haz) begin
      m_ex.valid = 1'b0;  m_ex.ctrl = '0;  e.chk_data = 1'b0;
      if (f) m_fc = m_fc + 1; else m_bc = m_bc + 1;
    end else begin
      m_ex = d;
      if (!d.valid) m_ex.ctrl = '0;
      e.chk_data = 1'b1;
    end
    e.s = m_ex;  e.bc = m_bc;  e.fc = m_fc;
    q_ex.push_back(e);
  endtask

  // Issue an instruction and keep re-presenting it while the pipeline is stalled.
  task automatic issue(input logic f, input slot_t d);
    logic st;
    int n = 0;
    step(1'b0, f, d, st);
    while (st && n < 4) begin
      step(1'b0, 1'b0, d, st);
      n++;
    end
    if (st) begin
      total++;  bad++;
      $display("FAIL stall_persist: stall still 1 after %0d re-presentations", n);
    end
  endtask

  // Combinational stall, sampled mid-cycle after the inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q_stall.size() > 0) check("stall", 64'(stall), 64'(q_stall.pop_front()));
    end
  end

  // Registered EX slot, sampled just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_ex.size() > 0) begin
        e = q_ex.pop_front();
        check("ex_valid", 64'(ex_valid), 64'(e.s.valid));
        check("ex_ctrl", 64'(ex_ctrl), 64'(e.s.ctrl));
        if (e.chk_data) begin
          check("ex_pc", 64'(ex_pc), 64'(e.s.pc));
          check("ex_rd1", 64'(ex_rd1), 64'(e.s.rd1));
          check("ex_rd2", 64'(ex_rd2), 64'(e.s.rd2));
          check("ex_imm", 64'(ex_imm), 64'(e.s.imm));
          check("ex_rs1", 64'(ex_rs1), 64'(e.s.rs1));
          check("ex_rs2", 64'(ex_rs2), 64'(e.s.rs2));
          check("ex_rd", 64'(ex_rd), 64'(e.s.rd));
          check("ex_funct3", 64'(ex_funct3), 64'(e.s.f3));
          check("ex_funct7", 64'(ex_funct7), 64'(e.s.f7));
        end
`ifdef IDEX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'(e.bc));
        check("flush_cnt", 64'(flush_cnt), 64'(e.fc));
`endif
      end
    end
  end

  localparam logic [9:0] C_LW   = 10'h00F;
  localparam logic [9:0] C_ADD  = 10'h044;
  localparam logic [9:0] C_ADDI = 10'h045;
  localparam logic [9:0] C_JAL  = 10'h205;
  localparam logic [9:0] C_NOP  = 10'h000;

  initial begin
    logic st;
    slot_t d;
    logic prev_st;

    reset = 1'b1;  flush = 1'b0;  id_valid = 1'b0;  id_ctrl = '0;  id_pc = '0;
    id_rd1 = '0;  id_rd2 = '0;  id_imm = '0;  id_rs1 = '0;  id_rs2 = '0;  id_rd = '0;
    id_funct3 = '0;  id_funct7 = '0;

    // Reset with nonzero inputs, then the first real capture.
    step(1'b1, 1'b1, mk(1'b1, C_LW, 5'd5, 5'd5, 5'd5), st);
    step(1'b1, 1'b0, mk(1'b1, 10'h3FF, 5'd7, 5'd7, 5'd7), st);
    issue(1'b0, mk(1'b1, 10'h004, 5'd1, 5'd2, 5'd3));

    // Load-use: lw x5 then add x6,x5,x1 costs one bubble.
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd5));
    issue(1'b0, mk(1'b1, C_ADD, 5'd5, 5'd1, 5'd6));
    issue(1'b0, mk(1'b0, C_NOP, 5'd0, 5'd0, 5'd0));

    // Load to x0 never hazards.
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd0));
    issue(1'b0, mk(1'b1, C_ADD, 5'd0, 5'd0, 5'd7));

    // Hazard overridden by flush.
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd5));
    issue(1'b1, mk(1'b1, C_ADD, 5'd5, 5'd1, 5'd6));

    // Jump ignores rs1.
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd5));
    issue(1'b0, mk(1'b1, C_JAL, 5'd5, 5'd0, 5'd1));

    // Back-to-back dependent loads, then independent loads; invalid decode never stalls.
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd5));
    issue(1'b0, mk(1'b1, C_LW, 5'd5, 5'd0, 5'd6));
    issue(1'b0, mk(1'b1, C_LW, 5'd2, 5'd0, 5'd8));
    issue(1'b0, mk(1'b0, C_ADD, 5'd8, 5'd8, 5'd9));
    issue(1'b0, mk(1'b1, C_ADDI, 5'd9, 5'd8, 5'd10));

    // Counter scenario from a clean reset: 3 hazards, 2 flushes, 1 combined.
    step(1'b1, 1'b0, mk(1'b0, C_NOP, 5'd0, 5'd0, 5'd0), st);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd4));
      issue(1'b0, mk(1'b1, C_ADD, 5'd2, 5'd4, 5'd3));
    end
    issue(1'b1, mk(1'b1, C_ADD, 5'd1, 5'd2, 5'd3));
    issue(1'b1, mk(1'b1, C_ADD, 5'd1, 5'd2, 5'd3));
    issue(1'b0, mk(1'b1, C_LW, 5'd1, 5'd0, 5'd4));
    issue(1'b1, mk(1'b1, C_ADD, 5'd4, 5'd2, 5'd3));

    // Random traffic with a small register window so hazards are frequent.
    prev_st = 1'b0;
    d = mk(1'b0, C_NOP, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3000; i++) begin
      logic r, f;
      if (!prev_st) begin
        d = mk($urandom_range(0, 99) < 85, 10'($urandom),
               AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
        d.ctrl[3] = $urandom_range(0, 99) < 45;
      end
      r = $urandom_range(0, 99) < 2;
      f = $urandom_range(0, 99) < 10;
      step(r, f, d, prev_st);
    end

    repeat (3) @(negedge clk);
    if (q_ex.size() != 0 || q_stall.size() != 0) begin
      total++;  bad++;
      $display("FAIL drain: %0d ex / %0d stall entries left, expected 0", q_ex.size(), q_stall.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
